// File: rtl/camera_line_packer.sv
// camera_line_packer: samples an 8-bit RGB565 camera bus, packs bytes into 32-bit words and
// writes them into a two-bank ping-pong line buffer, announcing each completed line.
module camera_line_packer #(
    parameter int nrOfEntries = 512
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           vsync,
    input  logic                           href,
    input  logic [7:0]                     camData,
    output logic [$clog2(nrOfEntries)-1:0] address,
    output logic                           writeEnable,
    output logic [31:0]                    dataOut,
    output logic                           lineReady,
    output logic                           lineBank,
    output logic [$clog2(nrOfEntries)-1:0] lineWords,
    output logic                           frameStart,
    output logic                           overflow
);
    localparam int AW = $clog2(nrOfEntries);
    localparam logic [AW-1:0] HALF = AW'(nrOfEntries / 2);

    typedef enum logic [1:0] {IDLE, WAIT_LINE, LINE} state_t;

    state_t          state, state_n;
    logic            vs_r, vs_p, hr_r;
    logic [7:0]      d_r;
    logic            vs_rise, vs_fall;
    logic            frame_go, byte_go, line_end;
    logic            full, flush, wr_fire;
    logic [1:0]      phase;
    logic            bank;
    logic [AW-1:0]   word_idx;
    logic [31:0]     word_q, word_n;
    logic            wr_req;
    logic [AW-1:0]   wr_addr;
    logic [31:0]     wr_data;
    logic            rdy_req, rdy_late, rdy_bank, late_q, rdy_fire;
    logic [AW-1:0]   rdy_words;

    assign vs_rise  = vs_r & ~vs_p;
    assign vs_fall  = ~vs_r & vs_p;
    assign full     = word_idx == HALF;
    assign flush    = line_end && phase != 2'd0;
    assign wr_fire  = (byte_go && phase == 2'd3) || flush;
    assign word_n   = (phase == 2'd0 ? 32'h0 : word_q) | ({d_r, 24'h0} >> {phase, 3'b000});
    // a flushed line announces itself one cycle after its flush write
    assign rdy_fire = (rdy_req && !rdy_late) || late_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n  = state;
        frame_go = 1'b0;
        byte_go  = 1'b0;
        line_end = 1'b0;
        case (state)
            IDLE: begin
                if (vs_fall && enable) begin
                    state_n  = WAIT_LINE;
                    frame_go = 1'b1;
                end
            end
            WAIT_LINE: begin
                if (vs_rise) state_n = IDLE;
                else if (hr_r) begin
                    state_n = LINE;
                    byte_go = 1'b1;
                end
            end
            LINE: begin
                if (vs_rise) state_n = IDLE;
                else if (hr_r) byte_go = 1'b1;
                else begin
                    state_n  = WAIT_LINE;
                    line_end = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vs_r        <= 1'b0;
            vs_p        <= 1'b0;
            hr_r        <= 1'b0;
            d_r         <= '0;
            phase       <= '0;
            bank        <= 1'b0;
            word_idx    <= '0;
            word_q      <= '0;
            wr_req      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rdy_req     <= 1'b0;
            rdy_late    <= 1'b0;
            rdy_bank    <= 1'b0;
            rdy_words   <= '0;
            late_q      <= 1'b0;
            address     <= '0;
            writeEnable <= 1'b0;
            dataOut     <= '0;
            lineReady   <= 1'b0;
            lineBank    <= 1'b0;
            lineWords   <= '0;
            frameStart  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            vs_r       <= vsync;
            vs_p       <= vs_r;
            hr_r       <= href;
            d_r        <= camData;
            frameStart <= frame_go;
            if (frame_go) overflow <= 1'b0;
            else if (wr_fire && full) overflow <= 1'b1;
            if (frame_go) bank <= 1'b0;
            else if (line_end) bank <= ~bank;
            if (frame_go || line_end) phase <= '0;
            else if (byte_go) phase <= phase + 2'd1;
            if (frame_go || line_end) word_idx <= '0;
            else if (wr_fire && !full) word_idx <= word_idx + 1'b1;
            if (byte_go) word_q <= word_n;
            wr_req  <= wr_fire && !full;
            wr_addr <= {bank, word_idx[AW-2:0]};
            wr_data <= line_end ? word_q : word_n;
            rdy_req <= line_end;
            if (line_end) begin
                rdy_late  <= flush && !full;
                rdy_bank  <= bank;
                rdy_words <= word_idx + AW'(flush && !full);
            end
            late_q      <= rdy_req && rdy_late;
            writeEnable <= wr_req;
            if (wr_req) begin
                address <= wr_addr;
                dataOut <= wr_data;
            end
            lineReady <= rdy_fire;
            if (rdy_fire) begin
                lineBank  <= rdy_bank;
                lineWords <= rdy_words;
            end
        end
    end
endmodule

// File: doc/camera_line_packer.md
# camera_line_packer

Pixel-clock-domain front end of the camera path: samples the 8-bit parallel camera bus (RGB565, two bytes per pixel) under `vsync`/`href`, packs four bytes into one 32-bit word and writes it into the 512-entry dual-port line buffer's write port. The buffer is split into two line banks used in ping-pong fashion. Each completed line is announced to the system-clock reader through a bank index and word count.

## Interface
- `nrOfEntries`, 512, depth of the downstream line buffer; must be a power of two ≥ 4. Each bank holds `nrOfEntries/2` words.
- `clock` in 1: camera pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: capture enable; sampled only at frame start.
- `vsync` in 1: camera vertical sync, high during vertical blanking.
- `href` in 1: camera line-valid.
- `camData` in 8: camera data byte.
- `address` out $clog2(nrOfEntries): buffer write address = {bank, wordIndex}.
- `writeEnable` out 1: buffer write strobe.
- `dataOut` out 32: buffer write data.
- `lineReady` out 1: one-cycle pulse when a line is complete in `lineBank`.
- `lineBank` out 1: bank holding the completed line; valid while `lineReady`=1, held afterwards.
- `lineWords` out $clog2(nrOfEntries): number of words written for that line (0..nrOfEntries/2).
- `frameStart` out 1: one-cycle pulse when a capture frame begins.
- `overflow` out 1: sticky; a line exceeded nrOfEntries/2 words. Cleared at `frameStart`.

## Operation
- Input stage: `vsync`, `href` and `camData` are registered once. All decisions below use the registered copies (`vsR`, `hrR`, `dR`) and the previous `vsR`.
- States:
  - IDLE -> WAIT_LINE on a `vsR` falling edge with `enable`=1. In that same cycle, pulse `frameStart`, clear `overflow`, set the bank to 0.
  - WAIT_LINE -> LINE when `hrR`=1. The byte in that cycle is byte 0.
  - LINE -> WAIT_LINE on `hrR` falling, after the line-end actions below.
  - `vsR` rising in WAIT_LINE or LINE -> IDLE. Any partial line is discarded: no flush, no `lineReady`.
- Packing, LINE state:
  - A 2-bit byte phase selects the lane: byte0->[31:24], byte1->[23:16], byte2->[15:8], byte3->[7:0]. The first pixel therefore lands in [31:16].
  - When phase 3 completes, write the word at wordIndex, then increment wordIndex. The byte phase wraps 3->0.
- Line end (`hrR` falling):
  - If phase ≠ 0, flush the partial word with unfilled lanes zero and count it.
  - Then pulse `lineReady` with `lineBank`=current bank and `lineWords`=words written.
  - Toggle the bank, reset wordIndex and phase to 0.
  - Zero-length lines (href high for 0 bytes cannot occur; href high <4 bytes) yield `lineWords`=1.
- Overflow: when wordIndex = nrOfEntries/2, further completed words are not written and not counted, and `overflow` is set. `lineWords` saturates at nrOfEntries/2 and the wrap into the other bank never happens.
- `enable` low at a frame start keeps the block in IDLE for that whole frame. Changing `enable` mid-frame has no effect.

## Timing
- Reset values:
  - Outputs: `address`=0, `writeEnable`=0, `dataOut`=0, `lineReady`=0, `lineBank`=0, `lineWords`=0, `frameStart`=0, `overflow`=0.
  - Internal: state IDLE, phase 0, bank 0.
- Reset asserted mid-frame returns the block to IDLE. It then waits for the next `vsync` falling edge and emits no `lineReady` for the interrupted line.
- Latency from pins:
  - Byte 3 sampled at pins on edge n -> `writeEnable`=1 with valid `address`/`dataOut` in the cycle after edge n+2. Write pulses are single-cycle.
  - `href` falling at pins on edge n -> flush write (if any) after edge n+2.
  - `lineReady` follows one cycle after the flush write. Without a flush, it is asserted after edge n+2.
- Outputs are registered, and `address`/`dataOut` are stable only while `writeEnable`=1.
- The reader must consume a bank within one line time. There is no back-pressure.

## Test plan
- Frame with `enable`=1, one line of bytes 0x01..0x08 -> writes 0x01020304 @ addr 0 and 0x05060708 @ addr 1. Then `lineReady` with `lineBank`=0, `lineWords`=2.
- Two successive 8-byte lines -> second line written at addrs 256/257, `lineBank`=1. A third line returns to bank 0.
- Line of 6 bytes 0xA1..0xA6 -> writes 0xA1A2A3A4 then flush 0xA5A60000; `lineWords`=2.
- 1028-byte line (257 words) -> 256 writes, addr 0..255, the 257th not written. `lineWords`=256, `overflow`=1, cleared by next `frameStart`.
- `enable`=0 at the `vsync` falling edge -> no `frameStart` and no writes for that frame. `enable`=1 at the next frame captures normally.
- `reset` pulse after byte 2 of a line -> all outputs 0, no write or `lineReady`. Next frame's first line lands at addr 0, bank 0.
